// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data requesters.
// Data wins ties; a starvation counter forces a fetch grant after a run of data grants.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write_en,
  input  logic [3:0]  d_data_en,
  input  logic [31:0] d_data_i,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic        m_write_en,
  output logic [3:0]  m_data_en,
  output logic [31:0] m_data_i,
  input  logic [31:0] m_data_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_FETCH,
    SEL_DATA
  } sel_t;

  sel_t                   sel;
  logic [3:0]             starve_cnt;
  logic                   force_fetch;
  logic                   accept;
  logic                   read_accept;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [MEM_LATENCY-1:0] pipe_owner;
  logic                   i_ret;
  logic                   d_ret;
  logic [31:0]            i_rdata_q;
  logic [31:0]            d_rdata_q;

  // Reset masks the selection so every request-side output reads 0 while reset is held.
  always_comb begin
    force_fetch = (starve_cnt == LIMIT) && i_req;
    sel         = SEL_NONE;
    if (reset)            sel = SEL_NONE;
    else if (force_fetch) sel = SEL_FETCH;
    else if (d_req)       sel = SEL_DATA;
    else if (i_req)       sel = SEL_FETCH;
  end

  always_comb begin
    m_addr     = 32'h0;
    m_write_en = 1'b0;
    m_data_en  = 4'b0000;
    m_data_i   = 32'h0;
    case (sel)
      SEL_FETCH: begin
        m_addr    = i_addr;
        m_data_en = 4'b1111;
      end
      SEL_DATA: begin
        m_addr     = d_addr;
        m_write_en = d_write_en;
        m_data_en  = d_data_en;
        m_data_i   = d_data_i;
      end
      default: ;
    endcase
  end

  assign m_valid     = ~reset & (i_req | d_req);
  assign accept      = m_valid & m_ready;
  assign i_gnt       = accept & (sel == SEL_FETCH);
  assign d_gnt       = accept & (sel == SEL_DATA);
  assign read_accept = i_gnt | (d_gnt & ~d_write_en);

  // Counts data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (!i_req || i_gnt)
      starve_cnt <= 4'd0;
    else if (d_gnt && (starve_cnt < LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Fixed-latency return tracker; owner bit 1 marks a data load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      pipe_valid[0] <= read_accept;
      pipe_owner[0] <= d_gnt;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
      end
    end
  end

  assign i_ret = ~reset & pipe_valid[MEM_LATENCY-1] & ~pipe_owner[MEM_LATENCY-1];
  assign d_ret = ~reset & pipe_valid[MEM_LATENCY-1] &  pipe_owner[MEM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      if (i_ret) i_rdata_q <= m_data_o;
      if (d_ret) d_rdata_q <= m_data_o;
    end
  end

  assign i_rvalid = i_ret;
  assign d_rvalid = d_ret;
  assign i_rdata  = reset ? 32'h0 : (i_ret ? m_data_o : i_rdata_q);
  assign d_rdata  = reset ? 32'h0 : (d_ret ? m_data_o : d_rdata_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbiter model predicts grants
// and memory-side outputs, and a queue of expected returns is checked against rvalid/rdata.
module tb_mem_port_arbiter;

  localparam int LAT   = 3;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write_en;
  logic [3:0]  d_data_en;
  logic [31:0] d_data_i;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic        m_write_en;
  logic [3:0]  m_data_en;
  logic [31:0] m_data_i;
  logic [31:0] m_data_o;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write_en(d_write_en), .d_data_en(d_data_en),
    .d_data_i(d_data_i), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_write_en(m_write_en),
    .m_data_en(m_data_en), .m_data_i(m_data_i), .m_data_o(m_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit owner_data;
  } ret_t;

  ret_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          model_cnt = 0;
  logic [31:0] last_i = 32'h0;
  logic [31:0] last_d = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Drives one cycle, checks the settled outputs at the falling edge, then advances the model.
  task automatic applyStimulus(input bit rst, input bit ir, input logic [31:0] ia,
                               input bit dr, input logic [31:0] da, input bit dwe,
                               input logic [3:0] den, input logic [31:0] dd, input bit rdy);
    bit          fetch_wins, data_wins, acc, exp_iv, exp_dv;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_en;
    bit          exp_we;
    ret_t        r;
    @(posedge clk);
    #1;
    reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
    d_write_en = dwe; d_data_en = den; d_data_i = dd; m_ready = rdy;
    m_data_o = $urandom;
    @(negedge clk);
    if (rst) begin
      checkOutput("rst_m_valid", 32'(m_valid), 0);
      checkOutput("rst_i_gnt", 32'(i_gnt), 0);
      checkOutput("rst_d_gnt", 32'(d_gnt), 0);
      checkOutput("rst_m_addr", m_addr, 0);
      checkOutput("rst_m_we", 32'(m_write_en), 0);
      checkOutput("rst_m_en", 32'(m_data_en), 0);
      checkOutput("rst_m_wdata", m_data_i, 0);
      checkOutput("rst_i_rvalid", 32'(i_rvalid), 0);
      checkOutput("rst_d_rvalid", 32'(d_rvalid), 0);
      checkOutput("rst_i_rdata", i_rdata, 0);
      checkOutput("rst_d_rdata", d_rdata, 0);
      sb.delete();
      model_cnt = 0;
      last_i = 32'h0;
      last_d = 32'h0;
    end else begin
      fetch_wins = ir && (!dr || model_cnt == LIMIT);
      data_wins  = dr && !fetch_wins;
      acc        = (ir || dr) && rdy;
      exp_addr = 0; exp_we = 0; exp_en = 0; exp_wdata = 0;
      if (fetch_wins) begin
        exp_addr = ia; exp_en = 4'hF;
      end else if (data_wins) begin
        exp_addr = da; exp_we = dwe; exp_en = den; exp_wdata = dd;
      end
      checkOutput("m_valid", 32'(m_valid), 32'(ir || dr));
      checkOutput("i_gnt", 32'(i_gnt), 32'(acc && fetch_wins));
      checkOutput("d_gnt", 32'(d_gnt), 32'(acc && data_wins));
      checkOutput("m_addr", m_addr, exp_addr);
      checkOutput("m_write_en", 32'(m_write_en), 32'(exp_we));
      checkOutput("m_data_en", 32'(m_data_en), 32'(exp_en));
      checkOutput("m_data_i", m_data_i, exp_wdata);
      exp_iv = 0;
      exp_dv = 0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        r = sb.pop_front();
        if (r.owner_data) begin
          exp_dv = 1; last_d = m_data_o;
        end else begin
          exp_iv = 1; last_i = m_data_o;
        end
      end
      checkOutput("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
      checkOutput("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
      checkOutput("i_rdata", i_rdata, last_i);
      checkOutput("d_rdata", d_rdata, last_d);
      if (acc && (fetch_wins || (data_wins && !dwe)))
        sb.push_back('{due: cyc + LAT, owner_data: data_wins});
      if (!ir || (acc && fetch_wins)) model_cnt = 0;
      else if (acc && data_wins && model_cnt < LIMIT) model_cnt++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_write_en = 0;
    d_data_en = 0; d_data_i = 0; m_ready = 0; m_data_o = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h40, 1, 32'h80, 0, 4'hF, 0, 1);
    idle(1);

    // Single fetch
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0, 1);
    idle(LAT + 1);

    // Contention: data wins, fetch follows once data drops
    applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, 4'hF, 0, 1);
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0, 1);
    idle(LAT + 1);

    // Starvation: both held, pattern of four data grants then one fetch
    for (int k = 0; k < 15; k++)
      applyStimulus(0, 1, 32'h500, 1, 32'h300 + 32'(k * 4), 0, 4'hF, 0, 1);
    idle(LAT + 1);

    // Store with partial enables never returns
    applyStimulus(0, 0, 0, 1, 32'h600, 1, 4'b0011, 32'h1234, 1);
    idle(LAT + 2);

    // Backpressure with fetch pending: counter holds while m_ready is low
    applyStimulus(0, 1, 32'h700, 1, 32'h704, 0, 4'hF, 0, 0);
    applyStimulus(0, 1, 32'h700, 1, 32'h704, 0, 4'hF, 0, 0);
    applyStimulus(0, 1, 32'h700, 1, 32'h704, 0, 4'hF, 0, 1);
    applyStimulus(0, 1, 32'h700, 0, 0, 0, 0, 0, 1);
    idle(LAT + 1);

    // Stores issued while a load returns
    applyStimulus(0, 0, 0, 1, 32'h800, 0, 4'hF, 0, 1);
    for (int k = 0; k < LAT; k++)
      applyStimulus(0, 0, 0, 1, 32'h900 + 32'(k), 1, 4'b1100, 32'hCAFE0000 + 32'(k), 1);
    idle(2);

    // Reset one cycle after a read accept discards the in-flight return
    applyStimulus(0, 1, 32'hA00, 1, 32'hA04, 0, 4'hF, 0, 1);
    applyStimulus(1, 1, 32'hA00, 1, 32'hA04, 0, 4'hF, 0, 1);
    idle(5);

    // Random traffic
    for (int k = 0; k < 60; k++)
      applyStimulus(($urandom_range(0, 29) == 0), $urandom_range(0, 1), $urandom,
                    $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                    4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    idle(LAT + 2);

    checkOutput("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester and its data-memory requester.
- Grants at most one request per cycle and tracks in-flight reads through a fixed-latency return pipeline, so each read datum is routed back to the requester that issued it.
- Data requests have priority, since they belong to the older instruction. A starvation counter guarantees fetch forward progress.
- Sits between the core's imem/dmem drivers and the memory model.

Parameters:
- MEM_LATENCY, 1, cycles from an accepted read to m_data_o being valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before one fetch grant is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch read request
- i_addr  in  32  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_addr  in  32  data address
- d_write_en  in  1  1 = store, 0 = load
- d_data_en  in  4  byte enables
- d_data_i  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (loads only)
- d_rdata  out  32  load data
- m_valid  out  1  memory request valid
- m_ready  in  1  memory accepts request this cycle
- m_addr  out  32  memory address
- m_write_en  out  1  memory write enable
- m_data_en  out  4  memory byte enables
- m_data_i  out  32  memory write data
- m_data_o  in  32  memory read data, valid MEM_LATENCY cycles after accept

Behaviour:
- Reset:
  - i_gnt, d_gnt, i_rvalid and d_rvalid are 0; i_rdata and d_rdata are 0.
  - m_valid, m_write_en and m_data_en are 0; m_addr and m_data_i are 0.
  - The return pipeline is flushed and the starvation counter is 0.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is asserted for them after reset.
- Selection is combinational each cycle:
  - Force-fetch condition: starve_cnt == STARVE_LIMIT and i_req.
  - If the force-fetch condition holds, select fetch.
  - Otherwise, if d_req, select data.
  - Otherwise, if i_req, select fetch.
  - Otherwise, no selection.
- m_valid = i_req | d_req.
- m_addr, m_write_en, m_data_en and m_data_i come from the selected requester.
  - A fetch drives m_write_en = 0 and m_data_en = 4'b1111.
  - With no selection, all four are 0.
- Accept = m_valid & m_ready.
  - The selected requester's gnt is asserted only on accept, in the same cycle.
  - The unselected requester's gnt is 0.
  - Requesters hold req and payload until gnt.
- Starvation counter (4 bit):
  - Increments on a data accept while i_req = 1.
  - Clears on a fetch accept, or in any cycle with i_req = 0.
  - Holds otherwise, including when m_ready = 0.
  - Saturates at STARVE_LIMIT.
- Return pipeline:
  - Shift register of MEM_LATENCY entries {valid, owner}.
  - Entry 0 is loaded on accept of a read: a fetch, or a data access with d_write_en = 0.
  - Stores never enter the pipeline.
  - The last stage drives rvalid to its owner for exactly 1 cycle, with rdata = m_data_o.
  - The non-owner's rvalid stays 0 and its rdata holds its last value.
- Throughput:
  - One accept per cycle.
  - Back-to-back reads return in issue order, one per cycle.
  - The pipeline shifts every cycle regardless of m_ready.
  - Any accept pattern is legal with no stall logic.
- Simultaneous requests: only one is granted; the loser sees gnt = 0 and retries the next cycle.
- A store and a read returning in the same cycle is legal: the return is unaffected.

Test Plan:
- Single fetch, MEM_LATENCY = 1: i_req = 1, i_addr = 0x100, m_ready = 1 at cycle 0.
  - Cycle 0: i_gnt = 1, m_addr = 0x100, m_data_en = 4'b1111.
  - Cycle 1: i_rvalid = 1, i_rdata = m_data_o = 0xDEADBEEF.
  - d_rvalid stays 0 throughout.
- Contention: i_req = d_req = 1 with a data load at 0x200.
  - d_gnt = 1 and i_gnt = 0 in cycle 0; d_rvalid = 1 in cycle 1.
  - If d_req drops, i_gnt = 1 in cycle 1.
- Starvation, STARVE_LIMIT = 4: i_req held at 1 and d_req held at 1 continuously.
  - d_gnt for 4 cycles, then i_gnt in the 5th cycle, then d_gnt again.
  - The pattern repeats every 5 cycles.
- Store, no return: d_write_en = 1, d_data_en = 4'b0011, d_data_i = 0x1234.
  - m_write_en = 1, m_data_i = 0x1234, d_gnt = 1.
  - No d_rvalid in any later cycle.
- Backpressure, MEM_LATENCY = 3: m_ready = 0 for 2 cycles with d_req = 1.
  - No gnt while m_ready = 0 and the counter holds.
  - On m_ready = 1: d_gnt, then d_rvalid exactly 3 cycles later.
- Reset flush, MEM_LATENCY = 3: issue reads, assert reset 1 cycle after the accept.
  - No rvalid in the following 5 cycles; all outputs at their reset values.
